// File: rtl/mem_access.sv
// Memory-access stage: passes ALU/HI-LO results through for non-memory ops,
// runs loads/stores over a single-outstanding req/ack bus, stalls the
// pipeline for the duration, and aligns/extends load data big-endian.
//
// state | meaning
// IDLE  | no access in flight; new aligned memory op launches a bus request
// BUS   | bus_req held, waiting for bus_ack or timeout
// DONE  | transfer finished; writeback presented for one cycle, stall released
module mem_access #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int ADDR_W         = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [4:0]        mem_wd,
   input  logic              mem_wreg,
   input  logic [31:0]       mem_wdata,
   input  logic              mem_whilo,
   input  logic [31:0]       mem_hi,
   input  logic [31:0]       mem_lo,
   input  logic [3:0]        mem_op,
   input  logic [31:0]       mem_addr,
   input  logic [31:0]       mem_sdata,
   output logic [4:0]        wb_wd,
   output logic              wb_wreg,
   output logic [31:0]       wb_wdata,
   output logic              wb_whilo,
   output logic [31:0]       wb_hi,
   output logic [31:0]       wb_lo,
   output logic              stallreq,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [3:0]        bus_sel,
   output logic [31:0]       bus_wdata,
   input  logic              bus_ack,
   input  logic [31:0]       bus_rdata,
   output logic              mem_err
);

   typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

   state_t            state_q, state_d;
   logic              bus_req_q, bus_req_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
   logic [3:0]        bus_sel_q, bus_sel_d;
   logic [31:0]       bus_wdata_q, bus_wdata_d;
   logic              mem_err_q, mem_err_d;
   logic [7:0]        cnt_q, cnt_d;
   logic [31:0]       rbuf_q, rbuf_d;
   logic              tout_q, tout_d;

   logic        is_load, is_store, is_mem, is_byte, is_half, ld_signed, misalign;
   logic [3:0]  sel_c;
   logic [31:0] wdata_c, load_ext;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Decode op into size/direction, lane selects, store replication, misalignment
   always_comb begin
      is_load   = 1'b0;
      is_store  = 1'b0;
      is_byte   = 1'b0;
      is_half   = 1'b0;
      ld_signed = 1'b0;
      case (mem_op)
         4'd1: begin is_load = 1'b1; is_byte = 1'b1; ld_signed = 1'b1; end
         4'd2: begin is_load = 1'b1; is_byte = 1'b1; end
         4'd3: begin is_load = 1'b1; is_half = 1'b1; ld_signed = 1'b1; end
         4'd4: begin is_load = 1'b1; is_half = 1'b1; end
         4'd5: is_load = 1'b1;
         4'd6: begin is_store = 1'b1; is_byte = 1'b1; end
         4'd7: begin is_store = 1'b1; is_half = 1'b1; end
         4'd8: is_store = 1'b1;
         default: ;
      endcase
      is_mem = is_load | is_store;
      if (is_byte)      misalign = 1'b0;
      else if (is_half) misalign = mem_addr[0];
      else              misalign = is_mem && (mem_addr[1:0] != 2'b00);

      if (is_byte) begin
         case (mem_addr[1:0])
            2'd0:    sel_c = 4'b1000;
            2'd1:    sel_c = 4'b0100;
            2'd2:    sel_c = 4'b0010;
            default: sel_c = 4'b0001;
         endcase
      end else if (is_half) begin
         sel_c = mem_addr[1] ? 4'b0011 : 4'b1100;
      end else begin
         sel_c = 4'b1111;
      end

      if (!is_store)    wdata_c = 32'h0;
      else if (is_byte) wdata_c = {4{mem_sdata[7:0]}};
      else if (is_half) wdata_c = {2{mem_sdata[15:0]}};
      else              wdata_c = mem_sdata;
   end

   // Pick and extend the addressed lane(s) from the captured read data
   always_comb begin
      case (mem_addr[1:0])
         2'd0:    ld_byte = rbuf_q[31:24];
         2'd1:    ld_byte = rbuf_q[23:16];
         2'd2:    ld_byte = rbuf_q[15:8];
         default: ld_byte = rbuf_q[7:0];
      endcase
      ld_half = mem_addr[1] ? rbuf_q[15:0] : rbuf_q[31:16];
      if (is_byte)      load_ext = {{24{ld_signed & ld_byte[7]}}, ld_byte};
      else if (is_half) load_ext = {{16{ld_signed & ld_half[15]}}, ld_half};
      else              load_ext = rbuf_q;
   end

   // Next-state and registered bus outputs
   always_comb begin
      state_d     = state_q;
      bus_req_d   = bus_req_q;
      bus_we_d    = bus_we_q;
      bus_addr_d  = bus_addr_q;
      bus_sel_d   = bus_sel_q;
      bus_wdata_d = bus_wdata_q;
      mem_err_d   = 1'b0;
      cnt_d       = cnt_q;
      rbuf_d      = rbuf_q;
      tout_d      = tout_q;
      case (state_q)
         IDLE: begin
            if (is_mem && misalign) begin
               mem_err_d = 1'b1;
            end else if (is_mem) begin
               bus_req_d   = 1'b1;
               bus_we_d    = is_store;
               bus_addr_d  = ADDR_W'({mem_addr[31:2], 2'b00});
               bus_sel_d   = sel_c;
               bus_wdata_d = wdata_c;
               cnt_d       = 8'd0;
               tout_d      = 1'b0;
               state_d     = BUS;
            end
         end
         BUS: begin
            if (bus_ack) begin
               rbuf_d    = bus_rdata;
               bus_req_d = 1'b0;
               state_d   = DONE;
            end else if (cnt_q == 8'(TIMEOUT_CYCLES - 1)) begin
               bus_req_d = 1'b0;
               mem_err_d = 1'b1;
               tout_d    = 1'b1;
               state_d   = DONE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE: begin
            tout_d  = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and bus registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_addr_q  <= '0;
         bus_sel_q   <= 4'b0;
         bus_wdata_q <= 32'h0;
         mem_err_q   <= 1'b0;
         cnt_q       <= 8'd0;
         rbuf_q      <= 32'h0;
         tout_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         bus_req_q   <= bus_req_d;
         bus_we_q    <= bus_we_d;
         bus_addr_q  <= bus_addr_d;
         bus_sel_q   <= bus_sel_d;
         bus_wdata_q <= bus_wdata_d;
         mem_err_q   <= mem_err_d;
         cnt_q       <= cnt_d;
         rbuf_q      <= rbuf_d;
         tout_q      <= tout_d;
      end
   end

   // Writeback mux and stall; write enable held low until the access completes
   always_comb begin
      wb_wd    = mem_wd;
      wb_wreg  = mem_wreg;
      wb_wdata = mem_wdata;
      wb_whilo = mem_whilo;
      wb_hi    = mem_hi;
      wb_lo    = mem_lo;
      stallreq = 1'b0;
      if (rst) begin
         wb_wd    = 5'd0;
         wb_wreg  = 1'b0;
         wb_wdata = 32'h0;
         wb_whilo = 1'b0;
         wb_hi    = 32'h0;
         wb_lo    = 32'h0;
      end else if (is_mem) begin
         case (state_q)
            IDLE: begin
               wb_wreg  = 1'b0;
               stallreq = !misalign;
            end
            BUS: begin
               wb_wreg  = 1'b0;
               stallreq = 1'b1;
            end
            DONE: begin
               if (tout_q)       wb_wreg = 1'b0;
               else if (is_load) wb_wdata = load_ext;
            end
            default: ;
         endcase
      end
   end

   assign bus_req   = bus_req_q;
   assign bus_we    = bus_we_q;
   assign bus_addr  = bus_addr_q;
   assign bus_sel   = bus_sel_q;
   assign bus_wdata = bus_wdata_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed examples plus randomized loads/stores checked
// against a lane-arithmetic reference model.
module tb_mem_access;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd;
   logic        mem_wreg, mem_whilo;
   logic [31:0] mem_wdata, mem_hi, mem_lo, mem_addr, mem_sdata;
   logic [3:0]  mem_op;
   logic [4:0]  wb_wd;
   logic        wb_wreg, wb_whilo, stallreq;
   logic [31:0] wb_wdata, wb_hi, wb_lo;
   logic        bus_req, bus_we, bus_ack, mem_err;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_sel;

   int total = 0;
   int bad   = 0;

   mem_access #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
      .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
      .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
      .wb_whilo(wb_whilo), .wb_hi(wb_hi), .wb_lo(wb_lo),
      .stallreq(stallreq),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_sel(bus_sel), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access size in bytes (0 = not a memory op)
   function automatic int m_size(input logic [3:0] op);
      case (op)
         4'd1, 4'd2, 4'd6: return 1;
         4'd3, 4'd4, 4'd7: return 2;
         4'd5, 4'd8:       return 4;
         default:          return 0;
      endcase
   endfunction

   function automatic bit m_is_load(input logic [3:0] op);
      return (op >= 4'd1 && op <= 4'd5);
   endfunction

   function automatic bit m_misalign(input logic [3:0] op, input logic [31:0] a);
      int sz = m_size(op);
      return (sz > 1) && ((a % sz) != 0);
   endfunction

   // Big-endian: byte offset k occupies bits [31-8k -: 8]
   function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [31:0] a);
      int sz = m_size(op);
      int off = (sz == 4) ? 0 : int'(a % 4);
      logic [3:0] s = 4'b0;
      for (int k = 0; k < sz; k++) s[3 - off - k] = 1'b1;
      return s;
   endfunction

   function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] d);
      int sz = m_size(op);
      if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   function automatic logic [31:0] m_load(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] rd);
      int sz = m_size(op);
      int off = (sz == 4) ? 0 : int'(a % 4);
      longint v = longint'((rd >> (8 * (4 - off - sz))) & ((64'd1 << (8 * sz)) - 1));
      bit sgn = (op == 4'd1 || op == 4'd3);
      if (sgn && v >= (64'd1 << (8 * sz - 1))) v = v - (longint'(1) << (8 * sz));
      return 32'(v);
   endfunction

   task automatic set_alu();
      mem_op    = 4'd0;
      mem_wreg  = 1'b0;
      mem_whilo = 1'b0;
   endtask

   // One instruction through the stage; ack_wait < 0 means the bus never answers
   task automatic run_access(input logic [3:0] op, input logic [31:0] addr,
                             input logic [31:0] sdata, input logic [31:0] rdata,
                             input int ack_wait);
      int n;
      bit ld, tout;
      ld = m_is_load(op);
      mem_op    = op;
      mem_addr  = addr;
      mem_sdata = sdata;
      mem_wdata = addr;
      mem_wreg  = ld;
      mem_wd    = 5'($urandom_range(1, 31));
      mem_hi    = $urandom;
      mem_lo    = $urandom;
      mem_whilo = 1'b0;
      #1;
      if (m_misalign(op, addr)) begin
         total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL misalign_stall op=%0d addr=%h got=%b want=0", op, addr, stallreq); end
         total++; if (wb_wreg !== 1'b0) begin bad++; $display("FAIL misalign_wreg op=%0d addr=%h got=%b want=0", op, addr, wb_wreg); end
         step();
         total++; if (mem_err !== 1'b1) begin bad++; $display("FAIL misalign_err op=%0d addr=%h got=%b want=1", op, addr, mem_err); end
         total++; if (bus_req !== 1'b0) begin bad++; $display("FAIL misalign_req op=%0d addr=%h got=%b want=0", op, addr, bus_req); end
         set_alu();
         step();
         total++; if (mem_err !== 1'b0) begin bad++; $display("FAIL misalign_err_pulse got=%b want=0", mem_err); end
         return;
      end
      total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL idle_stall op=%0d got=%b want=1", op, stallreq); end
      step();
      total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL req_rise op=%0d got=%b want=1", op, bus_req); end
      total++; if (bus_addr !== (addr & ~32'h3)) begin bad++; $display("FAIL bus_addr got=%h want=%h", bus_addr, addr & ~32'h3); end
      total++; if (bus_sel !== m_sel(op, addr)) begin bad++; $display("FAIL bus_sel op=%0d addr=%h got=%b want=%b", op, addr, bus_sel, m_sel(op, addr)); end
      total++; if (bus_we !== !ld) begin bad++; $display("FAIL bus_we op=%0d got=%b want=%b", op, bus_we, !ld); end
      if (!ld) begin
         total++; if (bus_wdata !== m_wdata(op, sdata)) begin bad++; $display("FAIL bus_wdata op=%0d got=%h want=%h", op, bus_wdata, m_wdata(op, sdata)); end
      end
      n = 0;
      while (bus_req === 1'b1 && n < 300) begin
         bus_ack   = (n == ack_wait);
         bus_rdata = (n == ack_wait) ? rdata : $urandom;
         #1;
         total++; if (stallreq !== 1'b1) begin bad++; $display("FAIL bus_stall cyc=%0d got=%b want=1", n, stallreq); end
         step();
         bus_ack = 1'b0;
         n++;
      end
      tout = (ack_wait < 0);
      total++; if (n !== (tout ? TO : ack_wait + 1)) begin bad++; $display("FAIL req_cycles op=%0d got=%0d want=%0d", op, n, tout ? TO : ack_wait + 1); end
      // an ack arriving in DONE must not disturb anything
      bus_ack   = 1'b1;
      bus_rdata = ~rdata;
      #1;
      total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL done_stall got=%b want=0", stallreq); end
      total++; if (mem_err !== tout) begin bad++; $display("FAIL done_err got=%b want=%b", mem_err, tout); end
      total++; if (wb_wreg !== (tout ? 1'b0 : ld)) begin bad++; $display("FAIL done_wreg op=%0d got=%b want=%b", op, wb_wreg, tout ? 1'b0 : ld); end
      total++; if (wb_hi !== mem_hi) begin bad++; $display("FAIL done_hi got=%h want=%h", wb_hi, mem_hi); end
      if (ld && !tout) begin
         total++; if (wb_wdata !== m_load(op, addr, rdata)) begin bad++; $display("FAIL load_data op=%0d addr=%h rd=%h got=%h want=%h", op, addr, rdata, wb_wdata, m_load(op, addr, rdata)); end
      end
      step();
      bus_ack = 1'b0;
      set_alu();
      #1;
      total++; if (bus_req !== 1'b0 || mem_err !== 1'b0 || stallreq !== 1'b0) begin bad++; $display("FAIL after_done req=%b err=%b stall=%b want=000", bus_req, mem_err, stallreq); end
   endtask

   task automatic test_reset();
      rst = 1'b1; bus_ack = 1'b0; bus_rdata = 32'h0;
      mem_op = 4'd5; mem_addr = 32'h40; mem_sdata = 32'h1; mem_wd = 5'd7;
      mem_wreg = 1'b1; mem_wdata = 32'hDEAD_BEEF; mem_whilo = 1'b1;
      mem_hi = 32'h1111_1111; mem_lo = 32'h2222_2222;
      step(); step();
      total++; if (bus_req !== 1'b0 || mem_err !== 1'b0 || bus_sel !== 4'b0 || bus_addr !== 32'h0 || bus_wdata !== 32'h0 || bus_we !== 1'b0) begin bad++; $display("FAIL reset_regs req=%b err=%b sel=%b addr=%h", bus_req, mem_err, bus_sel, bus_addr); end
      total++; if (wb_wdata !== 32'h0 || wb_wreg !== 1'b0 || wb_hi !== 32'h0 || wb_lo !== 32'h0 || wb_wd !== 5'd0 || wb_whilo !== 1'b0) begin bad++; $display("FAIL reset_wb wdata=%h wreg=%b hi=%h", wb_wdata, wb_wreg, wb_hi); end
      total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stallreq); end
      set_alu();
      rst = 1'b0;
      step();
   endtask

   task automatic test_passthrough();
      mem_op = 4'd0; mem_wdata = 32'h1234_5678; mem_wd = 5'd3; mem_wreg = 1'b1;
      #1;
      total++; if (wb_wdata !== 32'h1234_5678 || wb_wd !== 5'd3 || wb_wreg !== 1'b1 || stallreq !== 1'b0) begin bad++; $display("FAIL alu_example wdata=%h wd=%0d wreg=%b stall=%b", wb_wdata, wb_wd, wb_wreg, stallreq); end
      for (int i = 0; i < 8; i++) begin
         mem_op    = (i == 0) ? 4'd0 : 4'($urandom_range(9, 15));
         mem_addr  = $urandom;
         mem_wdata = $urandom; mem_wd = 5'($urandom); mem_wreg = 1'($urandom);
         mem_whilo = 1'($urandom); mem_hi = $urandom; mem_lo = $urandom;
         #1;
         total++; if (wb_wdata !== mem_wdata || wb_wd !== mem_wd || wb_wreg !== mem_wreg || wb_whilo !== mem_whilo || wb_hi !== mem_hi || wb_lo !== mem_lo) begin bad++; $display("FAIL alu_pass op=%0d wdata=%h want=%h", mem_op, wb_wdata, mem_wdata); end
         total++; if (stallreq !== 1'b0) begin bad++; $display("FAIL alu_stall op=%0d got=%b want=0", mem_op, stallreq); end
         step();
         total++; if (bus_req !== 1'b0 || mem_err !== 1'b0) begin bad++; $display("FAIL alu_bus op=%0d req=%b err=%b want=0", mem_op, bus_req, mem_err); end
      end
      set_alu();
   endtask

   task automatic test_examples();
      run_access(4'd1, 32'h101, 32'h0, 32'h1180_2233, 2);
      run_access(4'd7, 32'h202, 32'hAAAA_BEEF, 32'h0, 1);
      run_access(4'd6, 32'h303, 32'h1234_56A5, 32'h0, 0);
      run_access(4'd4, 32'h402, 32'h0, 32'h1234_8001, 0);
   endtask

   task automatic test_misalign();
      run_access(4'd5, 32'h6, 32'h0, 32'h0, 0);
      run_access(4'd3, 32'h103, 32'h0, 32'h0, 0);
      run_access(4'd8, 32'h201, 32'h0, 32'h0, 0);
      run_access(4'd7, 32'h305, 32'h0, 32'h0, 0);
   endtask

   task automatic test_timeout();
      run_access(4'd5, 32'h40, 32'h0, 32'h0, -1);
      run_access(4'd8, 32'h44, 32'hCAFE_F00D, 32'h0, -1);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 30; i++) begin
         logic [3:0] op = 4'($urandom_range(1, 8));
         logic [31:0] a = $urandom;
         a = (i % 3 == 0) ? a : (a & ~(32'(m_size(op)) - 1));
         run_access(op, a, $urandom, $urandom, $urandom_range(0, 2));
      end
   endtask

   task automatic test_reset_mid();
      mem_op = 4'd5; mem_addr = 32'h80; mem_wreg = 1'b1; mem_wdata = 32'h80;
      step();
      step();
      total++; if (bus_req !== 1'b1) begin bad++; $display("FAIL mid_req_pre got=%b want=1", bus_req); end
      rst = 1'b1;
      step();
      total++; if (bus_req !== 1'b0 || stallreq !== 1'b0) begin bad++; $display("FAIL mid_reset req=%b stall=%b want=00", bus_req, stallreq); end
      rst = 1'b0;
      set_alu();
      mem_wdata = 32'h5555_0000;
      bus_ack = 1'b1; bus_rdata = 32'h9999_9999;
      step();
      bus_ack = 1'b0;
      #1;
      total++; if (wb_wdata !== 32'h5555_0000 || wb_wreg !== 1'b0 || stallreq !== 1'b0 || bus_req !== 1'b0 || mem_err !== 1'b0) begin bad++; $display("FAIL late_ack wdata=%h wreg=%b stall=%b req=%b", wb_wdata, wb_wreg, stallreq, bus_req); end
      run_access(4'd2, 32'h81, 32'h0, 32'h00F0_0000, 0);
   endtask

   initial begin
      test_reset();
      test_passthrough();
      test_examples();
      test_misalign();
      test_timeout();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage that sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Passes register-write and HI/LO results straight through for non-memory instructions.
- Runs loads and stores over a single-master request/acknowledge data bus, with a small FSM.
- Holds the pipeline via stallreq until the bus transfer completes, and aligns and extends load data big-endian.

Parameters:
TIMEOUT_CYCLES, 255, BUS state cycles without bus_ack before the access is aborted; 1..255, counter is 8 bits
ADDR_W, 32, width of bus_addr

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
mem_wd  in  5  destination register from EX/MEM
mem_wreg  in  1  register write enable from EX/MEM
mem_wdata  in  32  ALU result from EX/MEM
mem_whilo  in  1  HI/LO write enable from EX/MEM
mem_hi  in  32  HI value
mem_lo  in  32  LO value
mem_op  in  4  0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
mem_addr  in  32  effective address
mem_sdata  in  32  store data (rt)
wb_wd  out  5  to MEM/WB
wb_wreg  out  1  to MEM/WB
wb_wdata  out  32  to MEM/WB
wb_whilo  out  1  to MEM/WB
wb_hi  out  32  to MEM/WB
wb_lo  out  32  to MEM/WB
stallreq  out  1  stall request to pipeline control
bus_req  out  1  registered; access request
bus_we  out  1  registered; 1 store, 0 load
bus_addr  out  ADDR_W  registered; word-aligned address, bits[1:0] always 0
bus_sel  out  4  registered; byte enables, bit3 = bits 31:24
bus_wdata  out  32  registered; lane-replicated store data
bus_ack  in  1  single-cycle completion
bus_rdata  in  32  valid when bus_ack=1
mem_err  out  1  registered; one-cycle pulse on misalign or timeout

Behaviour:
- Reset: state IDLE; bus_req, bus_we, bus_sel, bus_addr, bus_wdata, mem_err, timeout counter and read buffer all 0.
- Reset: while rst=1 the combinational wb_* outputs are forced to 0 and stallreq to 0.
- Reset mid-access drops bus_req on that same edge.
- Non-memory op (mem_op 0 or 9-15): wb_* equal mem_* combinationally; stallreq=0; FSM stays IDLE.
- Byte lanes are big-endian:
  - Byte access: addr[1:0]=0 → sel 1000 (bits 31:24); 1 → 0100; 2 → 0010; 3 → 0001.
  - Halfword access: addr[1]=0 → sel 1100; addr[1]=1 → sel 0011.
  - Word access: sel 1111.
- Store data: SB replicates byte[7:0] to all 4 lanes; SH replicates half[15:0] to both halves.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]≠0.
  - No bus access is made; mem_err pulses next cycle; wb_wreg=0; stallreq=0.
- FSM states IDLE, BUS, DONE:
  - IDLE + aligned memory op: stallreq=1 combinationally; next edge registers bus_req=1 plus addr/we/sel/wdata; go BUS; counter cleared.
  - BUS: bus_req held; stallreq=1; counter increments each cycle.
  - BUS + bus_ack=1: capture bus_rdata; bus_req=0 on the next edge; go DONE.
  - BUS + counter=TIMEOUT_CYCLES−1 with no ack: bus_req=0; mem_err pulses; go DONE with wb_wreg forced 0.
  - DONE: stallreq=0 for exactly one cycle.
  - DONE, loads: wb_wdata = extended captured data, wb_wreg = mem_wreg.
  - DONE, stores: wb_wreg = mem_wreg (0 from decode).
  - DONE: next edge → IDLE, because EX/MEM has advanced.
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend; byte/halfword selected by the same lane mapping as bus_sel.
- bus_ack while in IDLE or DONE is ignored.
- The bus is always single-outstanding.
- HI/LO outputs pass through unchanged in every state.

Test Plan:
- ALU op, mem_op=0, mem_wdata=0x1234_5678, mem_wd=3, mem_wreg=1 → same-cycle wb_wdata=0x12345678, wb_wd=3, stallreq=0, bus_req never asserted.
- LB addr=0x101, bus_rdata=0x11_80_22_33, ack 2 cycles after bus_req → bus_addr=0x100, bus_sel=0100, stallreq high until DONE, wb_wdata=0xFFFF_FF80.
- SH addr=0x202, sdata=0xAAAA_BEEF → bus_we=1, bus_sel=0011, bus_wdata=0xBEEF_BEEF, bus_addr=0x200, wb_wreg=0.
- LW addr=0x6 → no bus_req, mem_err one-cycle pulse, wb_wreg=0, stallreq=0.
- LW aligned, TIMEOUT_CYCLES=4, no ack → bus_req high exactly 4 cycles, mem_err pulse, wb_wreg=0, FSM back to IDLE.
- rst=1 asserted while in BUS → next cycle bus_req=0, state IDLE, stallreq=0; a late bus_ack produces no writeback.
